// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Fetches one word per PC from memory and holds it for decode until accepted.
module pc_fetch_unit #(
  parameter int unsigned AddrSize   = 4,
  parameter int unsigned InstrSize  = 8,
  parameter int unsigned ResetPc    = 0,
  parameter int unsigned MemTimeout = 15
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [AddrSize-1:0]  NEXT_PC,
  input  logic                 MEM_READY,
  input  logic [InstrSize-1:0] MEM_DATA,
  input  logic                 DEC_READY,
  output logic [AddrSize-1:0]  PC,
  output logic [AddrSize-1:0]  PC_PLUS1,
  output logic                 FETCH_REQ,
  output logic [AddrSize-1:0]  FETCH_ADDR,
  output logic [InstrSize-1:0] INSTR,
  output logic                 INSTR_VALID,
  output logic                 FETCH_ERR
);

  localparam int unsigned CntW = (MemTimeout < 2) ? 1 : $clog2(MemTimeout);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AddrSize-1:0]  r_pc;
  logic [AddrSize-1:0]  w_pc_nxt;
  logic [InstrSize-1:0] r_instr;
  logic [InstrSize-1:0] w_instr_nxt;
  logic [CntW-1:0]      r_cnt;
  logic [CntW-1:0]      w_cnt_nxt;
  logic                 r_fetch_req;
  logic                 r_instr_valid;
  logic                 r_fetch_err;
  logic                 w_err_nxt;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered status flags, all following the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc          <= AddrSize'(ResetPc);
      r_instr       <= '0;
      r_cnt         <= '0;
      r_fetch_req   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_fetch_req   <= (w_state_nxt == S_FETCH);
      r_instr_valid <= (w_state_nxt == S_HOLD);
      r_fetch_err   <= w_err_nxt;
    end
  end

  // Next-state logic; a ready on the final wait cycle still counts as success
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_fetch_err;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_cnt_nxt   = '0;
      end
      S_FETCH: begin
        if (MEM_READY) begin
          w_instr_nxt = MEM_DATA;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end else if (r_cnt == CntW'(MemTimeout - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      S_HOLD: begin
        if (DEC_READY) begin
          w_pc_nxt    = NEXT_PC;
          w_cnt_nxt   = '0;
          w_state_nxt = S_FETCH;
        end
      end
      S_ERROR: begin
        w_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign PC          = r_pc;
  assign PC_PLUS1    = r_pc + AddrSize'(1);
  assign FETCH_ADDR  = r_pc;
  assign FETCH_REQ   = r_fetch_req;
  assign INSTR       = r_instr;
  assign INSTR_VALID = r_instr_valid;
  assign FETCH_ERR   = r_fetch_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed bench for pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;

  localparam int unsigned AW = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned TO = 15;

  logic          CLK;
  logic          RESET_N;
  logic [AW-1:0] NEXT_PC;
  logic          MEM_READY;
  logic [IW-1:0] MEM_DATA;
  logic          DEC_READY;
  logic [AW-1:0] PC;
  logic [AW-1:0] PC_PLUS1;
  logic          FETCH_REQ;
  logic [AW-1:0] FETCH_ADDR;
  logic [IW-1:0] INSTR;
  logic          INSTR_VALID;
  logic          FETCH_ERR;

  pc_fetch_unit #(.AddrSize(AW), .InstrSize(IW), .ResetPc(0), .MemTimeout(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .NEXT_PC(NEXT_PC), .MEM_READY(MEM_READY),
    .MEM_DATA(MEM_DATA), .DEC_READY(DEC_READY), .PC(PC), .PC_PLUS1(PC_PLUS1),
    .FETCH_REQ(FETCH_REQ), .FETCH_ADDR(FETCH_ADDR), .INSTR(INSTR),
    .INSTR_VALID(INSTR_VALID), .FETCH_ERR(FETCH_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [IW-1:0] mem [16];

  // Model: what the fetcher is doing, expressed as activity flags
  localparam int PH_IDLE = 0, PH_WAIT_MEM = 1, PH_OFFER = 2, PH_DEAD = 3;
  int            m_phase;
  int            m_waited;
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_instr;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_waited = 0;
    m_pc     = '0;
    m_instr  = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic mr, input logic dr, input logic [AW-1:0] np);
    if (m_phase == PH_IDLE) begin
      m_phase  = PH_WAIT_MEM;
      m_waited = 0;
    end else if (m_phase == PH_WAIT_MEM) begin
      if (mr) begin
        m_instr = mem[m_pc];
        m_phase = PH_OFFER;
      end else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_err   = 1'b1;
          m_phase = PH_DEAD;
        end
      end
    end else if (m_phase == PH_OFFER) begin
      if (dr) begin
        m_pc     = np;
        m_phase  = PH_WAIT_MEM;
        m_waited = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    32'(PC),          32'(m_pc));
    chk({tag, ".pc1"},   32'(PC_PLUS1),    32'((m_pc + 1) % 16));
    chk({tag, ".addr"},  32'(FETCH_ADDR),  32'(m_pc));
    chk({tag, ".req"},   32'(FETCH_REQ),   32'(m_phase == PH_WAIT_MEM));
    chk({tag, ".valid"}, 32'(INSTR_VALID), 32'(m_phase == PH_OFFER));
    chk({tag, ".instr"}, 32'(INSTR),       32'(m_instr));
    chk({tag, ".err"},   32'(FETCH_ERR),   32'(m_err));
  endtask

  task automatic cycle(input string tag, input logic mr, input logic dr, input logic [AW-1:0] np);
    MEM_READY = mr;
    DEC_READY = dr;
    NEXT_PC   = np;
    MEM_DATA  = mr ? mem[FETCH_ADDR] : IW'($urandom);
    @(posedge CLK);
    model_step(mr, dr, np);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset(input string tag);
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge CLK);
    #1;
    check_all({tag, ".held"});
    #2;
    RESET_N = 1'b1;
  endtask

  logic [AW-1:0] seq_np;

  initial begin
    RESET_N   = 1'b0;
    NEXT_PC   = '0;
    MEM_READY = 1'b0;
    MEM_DATA  = '0;
    DEC_READY = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = IW'($urandom);
    model_reset();
    #4;
    check_all("por");
    @(posedge CLK);
    #3;
    RESET_N = 1'b1;

    // Straight-line run with wrap past 15
    for (int i = 0; i < 40; i++) begin
      seq_np = m_pc + AW'(1);
      cycle("seq", 1'b1, 1'b1, seq_np);
    end

    // Decode stall then redirect to 9
    do_reset("rst_a");
    cycle("stall_in", 1'b0, 1'b0, 4'd0);
    cycle("stall_in", 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) cycle("stall", 1'($urandom), 1'b0, 4'($urandom));
    cycle("jump", 1'b0, 1'b1, 4'd9);
    chk("jump.pc9", 32'(FETCH_ADDR), 32'd9);

    // Memory timeout on the 15th idle wait
    do_reset("rst_b");
    cycle("to_in", 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) cycle("to", 1'b0, 1'b1, 4'd0);
    chk("to.err", 32'(FETCH_ERR), 32'd1);
    for (int i = 0; i < 4; i++) cycle("dead", 1'b1, 1'b1, 4'($urandom));

    // Ready arriving on the last allowed wait cycle
    do_reset("rst_c");
    cycle("late_in", 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 14; i++) cycle("late", 1'b0, 1'b1, 4'd0);
    cycle("late_ok", 1'b1, 1'b0, 4'd0);
    chk("late.valid", 32'(INSTR_VALID), 32'd1);
    chk("late.instr", 32'(INSTR), 32'(mem[0]));

    // Reset during decode stall and during memory wait
    cycle("rh", 1'b0, 1'b1, 4'd5);
    cycle("rh", 1'b1, 1'b0, 4'd0);
    do_reset("rst_hold");
    cycle("rf", 1'b0, 1'b0, 4'd0);
    cycle("rf", 1'b0, 1'b0, 4'd0);
    cycle("rf", 1'b0, 1'b0, 4'd0);
    do_reset("rst_fetch");

    // Randomized traffic; memory occasionally goes quiet long enough to time out
    for (int seg = 0; seg < 8; seg++) begin
      int mr_pct;
      mr_pct = (seg % 4 == 3) ? 3 : 60;
      for (int i = 0; i < 60; i++) begin
        logic          mr;
        logic          dr;
        logic [AW-1:0] np;
        mr = ($urandom_range(0, 99) < mr_pct);
        dr = ($urandom_range(0, 99) < 55);
        np = ($urandom_range(0, 1) == 0) ? AW'(m_pc + 1) : AW'($urandom);
        cycle("rnd", mr, dr, np);
        if (m_phase == PH_DEAD && $urandom_range(0, 3) == 0) do_reset("rst_rnd");
      end
      do_reset("rst_seg");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
